ahb3lite_sram_ws: RTL and testbench

AHB3-Lite single-port SRAM slave with parametrised data width, depth, and independent read/write wait-state counts. It generates HREADYOUT from a data-phase state machine, merges sub-word writes via byte enables, and forwards just-written data to an immediately following read. It optionally signals a two-cycle ERROR response for out-of-range or misaligned accesses. It sits behind the AHB decoder/mux as a memory target, one instance per HSEL.

---
 rtl/ahb3lite_sram_ws.sv | 206 ++++++++++++++++++++
 tb/tb_ahb3lite_sram_ws.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite single-port SRAM slave with independent read/write wait states and write-to-read forwarding.
// Define AHB3LITE_SRAM_RANGE_ERR_EN to answer out-of-range/misaligned/oversize accesses with a two-cycle ERROR.
module ahb3lite_sram_ws #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int BYTES = HDATA_SIZE / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Word index aliases modulo the depth; out-of-range words are trapped earlier when checking is enabled.
    function automatic logic [IDX_W-1:0] wordIndex(input logic [HADDR_SIZE-1:0] addr);
        logic [HADDR_SIZE-1:0] word;
        word = addr >> OFF_W;
        return IDX_W'(word % HADDR_SIZE'(MEM_DEPTH));
    endfunction

    // Oversize transfers clamp to the full bus; misaligned low bits are dropped by aligning down.
    function automatic logic [BYTES-1:0] byteEnable(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [BYTES-1:0] be;
        int sz;
        int nb;
        int base;
        sz   = (int'(size) > OFF_W) ? OFF_W : int'(size);
        nb   = 1 << sz;
        base = (int'(off) / nb) * nb;
        be   = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= base && b < base + nb) begin
                be[b] = 1'b1;
            end
        end
        return be;
    endfunction

`ifdef AHB3LITE_SRAM_RANGE_ERR_EN
    function automatic logic rangeError(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
        logic [HADDR_SIZE-1:0] word;
        logic [HADDR_SIZE-1:0] lowMask;
        word    = addr >> OFF_W;
        lowMask = (HADDR_SIZE'(1) << size) - HADDR_SIZE'(1);
        if (int'(size) > OFF_W) begin
            return 1'b1;
        end
        if (word >= HADDR_SIZE'(MEM_DEPTH)) begin
            return 1'b1;
        end
        return (addr & lowMask) != '0;
    endfunction
`endif

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BYTES-1:0]      be_q, be_d;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d;

    logic                  accept;
    logic                  addrErr;
    logic [IDX_W-1:0]      idxA;
    logic [BYTES-1:0]      beA;
    logic [2:0]            waitSel;
    logic                  readyOut;
    logic                  respOut;
    logic                  loadRead;
    logic                  commit;
    logic [IDX_W-1:0]      rdIdx;
    logic [HDATA_SIZE-1:0] rdWord;
    logic                  unusedInputs;

    assign unusedInputs = ^{HBURST, HPROT};

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign idxA    = wordIndex(HADDR);
    assign beA     = byteEnable(HSIZE, HADDR[OFF_W-1:0]);
    assign waitSel = HWRITE ? WR_CNT : RD_CNT;

`ifdef AHB3LITE_SRAM_RANGE_ERR_EN
    assign addrErr = rangeError(HADDR, HSIZE);
`else
    assign addrErr = 1'b0;
`endif

    // IDLE, LAST and ERR2 all present a ready bus, so each may take the next address phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        idx_d    = idx_q;
        be_d     = be_q;
        readyOut = 1'b1;
        respOut  = 1'b0;
        loadRead = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                readyOut = 1'b0;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d  = ST_LAST;
                    loadRead = ~write_q;
                end
            end
            ST_ERR1: begin
                readyOut = 1'b0;
                respOut  = 1'b1;
                state_d  = ST_ERR2;
            end
            default: begin
                respOut = (state_q == ST_ERR2);
                commit  = (state_q == ST_LAST) & write_q;
                state_d = ST_IDLE;
                if (accept) begin
                    write_d = HWRITE;
                    idx_d   = idxA;
                    be_d    = beA;
                    if (addrErr) begin
                        state_d = ST_ERR1;
                    end else if (waitSel != 3'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = waitSel;
                    end else begin
                        state_d  = ST_LAST;
                        loadRead = ~HWRITE;
                    end
                end
            end
        endcase
    end

    // A zero-wait read issued during a write's LAST cycle sees the write's bytes before they reach the array.
    always_comb begin
        rdIdx  = (state_q == ST_WAIT) ? idx_q : idxA;
        rdWord = mem[rdIdx];
        for (int b = 0; b < BYTES; b++) begin
            if (commit && (idx_q == rdIdx) && be_q[b]) begin
                rdWord[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
        rdata_d = loadRead ? rdWord : rdata_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = readyOut;
    assign HRESP     = respOut;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Bench for ahb3lite_sram_ws: two instances (RD_WAIT=2/WR_WAIT=1 and zero-wait) checked against a byte-level memory model.
// Follows AHB3LITE_SRAM_RANGE_ERR_EN to choose between ERROR checks and address-aliasing checks.
module tb_ahb3lite_sram_ws;
    localparam int MAXQ = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstN;
    logic [1:0]           hsel;
    logic [1:0][15:0]     haddr;
    logic [1:0][31:0]     hwdata;
    logic [1:0][31:0]     hrdata;
    logic [1:0]           hwrite;
    logic [1:0][2:0]      hsize;
    logic [1:0][2:0]      hburst;
    logic [1:0][3:0]      hprot;
    logic [1:0][1:0]      htrans;
    logic [1:0]           hreadyout;
    logic [1:0]           hresp;

    for (genvar g = 0; g < 2; g++) begin : gDut
        ahb3lite_sram_ws #(
            .HADDR_SIZE(16),
            .HDATA_SIZE(32),
            .MEM_DEPTH (256),
            .RD_WAIT   (g == 0 ? 2 : 0),
            .WR_WAIT   (g == 0 ? 1 : 0)
        ) dut (
            .HCLK     (clk),
            .HRESETn  (rstN),
            .HSEL     (hsel[g]),
            .HADDR    (haddr[g]),
            .HWDATA   (hwdata[g]),
            .HRDATA   (hrdata[g]),
            .HWRITE   (hwrite[g]),
            .HSIZE    (hsize[g]),
            .HBURST   (hburst[g]),
            .HPROT    (hprot[g]),
            .HTRANS   (htrans[g]),
            .HREADY   (hreadyout[g]),
            .HREADYOUT(hreadyout[g]),
            .HRESP    (hresp[g])
        );
    end

    int compared;
    int mismatched;

    logic [7:0] mdl [2][1024];

    int          nItems;
    logic        sqSel   [MAXQ];
    logic [1:0]  sqTrans [MAXQ];
    logic        sqWrite [MAXQ];
    logic [15:0] sqAddr  [MAXQ];
    logic [2:0]  sqSize  [MAXQ];
    logic [2:0]  sqBurst [MAXQ];
    logic [31:0] sqData  [MAXQ];
    int          rsCyc       [MAXQ];
    logic [31:0] rsRdata     [MAXQ];
    logic        rsRespAny   [MAXQ];
    logic        rsRespFirst [MAXQ];
    logic        rsRespLast  [MAXQ];

    function automatic int rdWait(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int wrWait(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Reference memory: a flat byte array, address aliased modulo 1 KiB, byte lane = address mod 4.
    task automatic mdlWrite(input int d, input int addr, input int size, input logic [31:0] data);
        int nb;
        int base;
        nb   = 1 << size;
        base = (addr / nb) * nb;
        for (int k = 0; k < nb; k++) begin
            mdl[d][(base + k) % 1024] = data[8*((base + k) % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] mdlWord(input int d, input int addr);
        int base;
        base = (addr % 1024) & ~3;
        return {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
    endfunction

    function automatic logic [31:0] laneMask(input int addr, input int size);
        logic [31:0] m;
        int nb;
        int base;
        nb   = 1 << size;
        base = ((addr % 4) / nb) * nb;
        m    = '0;
        for (int k = 0; k < nb; k++) begin
            m[8*(base + k) +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic addItem(input logic sel, input logic [1:0] trans, input logic wr, input logic [15:0] addr,
                           input logic [2:0] size, input logic [31:0] data, input logic [2:0] burst);
        sqSel[nItems]   = sel;
        sqTrans[nItems] = trans;
        sqWrite[nItems] = wr;
        sqAddr[nItems]  = addr;
        sqSize[nItems]  = size;
        sqData[nItems]  = data;
        sqBurst[nItems] = burst;
        nItems++;
    endtask

    task automatic busIdle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'd0;
        hwrite[d] = 1'b0;
        haddr[d]  = '0;
        hsize[d]  = 3'd0;
        hburst[d] = 3'd0;
        hwdata[d] = '0;
    endtask

    // Pipelined master: called just after a rising edge; address of item i overlaps the data phase of item dp.
    task automatic applyStimulus(input int d);
        int i;
        int dp;
        int cyc;
        int guard;
        i = 0; dp = -1; cyc = 0; guard = 0;
        while ((i < nItems || dp >= 0) && guard < 1000) begin
            if (i < nItems) begin
                hsel[d]   = sqSel[i];
                htrans[d] = sqTrans[i];
                hwrite[d] = sqWrite[i];
                haddr[d]  = sqAddr[i];
                hsize[d]  = sqSize[i];
                hburst[d] = sqBurst[i];
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'd0; hwrite[d] = 1'b0;
                haddr[d] = '0; hsize[d] = 3'd0; hburst[d] = 3'd0;
            end
            hwdata[d] = (dp >= 0) ? sqData[dp] : 32'h0;
            @(negedge clk);
            if (dp >= 0) begin
                cyc++;
                if (cyc == 1) rsRespFirst[dp] = hresp[d];
                if (hresp[d]) rsRespAny[dp] = 1'b1;
            end
            if (hreadyout[d]) begin
                if (dp >= 0) begin
                    rsCyc[dp]      = cyc;
                    rsRdata[dp]    = hrdata[d];
                    rsRespLast[dp] = hresp[d];
                end
                if (i < nItems) begin
                    dp = i;
                    rsRespAny[dp] = 1'b0;
                    i++;
                end else begin
                    dp = -1;
                end
                cyc = 0;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL seq_timeout dut%0d issued %0d of %0d items", d, i, nItems);
        end
        busIdle(d);
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (hreadyout[d] !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hreadyout dut%0d got %b want 1", d, hreadyout[d]); end
            compared++;
            if (hresp[d] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hresp dut%0d got %b want 0", d, hresp[d]); end
            compared++;
            if (hrdata[d] !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hrdata dut%0d got %h want 0", d, hrdata[d]); end
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill;
        for (int d = 0; d < 2; d++) begin
            nItems = 0;
            for (int w = 0; w < 64; w++) begin
                addItem(1'b1, 2'd2, 1'b1, 16'(w * 4), 3'd2, $urandom, 3'd0);
            end
            applyStimulus(d);
            for (int k = 0; k < nItems; k++) begin
                compared++;
                if (rsCyc[k] !== 1 + wrWait(d)) begin
                    mismatched++; $display("[TB] FAIL fill_cycles dut%0d item%0d got %0d want %0d", d, k, rsCyc[k], 1 + wrWait(d));
                end
                mdlWrite(d, int'(sqAddr[k]), 2, sqData[k]);
            end
        end
    endtask

    task automatic test_wait_states;
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b1, 16'h0020, 3'd2, 32'hDEADBEEF, 3'd0);
        addItem(1'b1, 2'd2, 1'b0, 16'h0020, 3'd2, 32'h0, 3'd0);
        applyStimulus(0);
        mdlWrite(0, 16'h0020, 2, 32'hDEADBEEF);
        compared++;
        if (rsCyc[0] !== 2) begin mismatched++; $display("[TB] FAIL ws_write_cycles got %0d want 2", rsCyc[0]); end
        compared++;
        if (rsCyc[1] !== 3) begin mismatched++; $display("[TB] FAIL ws_read_cycles got %0d want 3", rsCyc[1]); end
        compared++;
        if (rsRdata[1] !== mdlWord(0, 16'h0020)) begin mismatched++; $display("[TB] FAIL ws_rdata got %h want %h", rsRdata[1], mdlWord(0, 16'h0020)); end
        compared++;
        if (rsRespAny[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_hresp got %b want 0", rsRespAny[1]); end
    endtask

    task automatic test_forwarding;
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b1, 16'h0040, 3'd2, 32'h11223344, 3'd0);
        addItem(1'b1, 2'd2, 1'b1, 16'h0041, 3'd0, 32'h5A5AAA5A, 3'd0);
        addItem(1'b1, 2'd2, 1'b0, 16'h0040, 3'd2, 32'h0, 3'd0);
        applyStimulus(1);
        mdlWrite(1, 16'h0040, 2, 32'h11223344);
        mdlWrite(1, 16'h0041, 0, 32'h5A5AAA5A);
        compared++;
        if (rsRdata[2] !== 32'h1122AA44) begin mismatched++; $display("[TB] FAIL fwd_rdata got %h want 1122aa44", rsRdata[2]); end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (rsCyc[k] !== 1) begin mismatched++; $display("[TB] FAIL fwd_cycles item%0d got %0d want 1", k, rsCyc[k]); end
        end
    endtask

    task automatic test_burst;
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b1, 16'h0100, 3'd2, 32'h1, 3'd3);
        addItem(1'b1, 2'd1, 1'b1, 16'h0104, 3'd2, 32'h0, 3'd3);
        addItem(1'b1, 2'd3, 1'b1, 16'h0104, 3'd2, 32'h2, 3'd3);
        addItem(1'b1, 2'd3, 1'b1, 16'h0108, 3'd2, 32'h3, 3'd3);
        addItem(1'b1, 2'd1, 1'b1, 16'h010C, 3'd2, 32'h0, 3'd3);
        addItem(1'b1, 2'd3, 1'b1, 16'h010C, 3'd2, 32'h4, 3'd3);
        addItem(1'b1, 2'd2, 1'b0, 16'h0100, 3'd2, 32'h0, 3'd3);
        addItem(1'b1, 2'd3, 1'b0, 16'h0104, 3'd2, 32'h0, 3'd3);
        addItem(1'b1, 2'd3, 1'b0, 16'h0108, 3'd2, 32'h0, 3'd3);
        addItem(1'b1, 2'd3, 1'b0, 16'h010C, 3'd2, 32'h0, 3'd3);
        applyStimulus(0);
        for (int k = 1; k <= 4; k++) mdlWrite(0, 16'h0100 + 4 * (k - 1), 2, 32'(k));
        compared++;
        if (rsCyc[1] !== 1 || rsRespAny[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL burst_busy1 got cyc=%0d resp=%b want cyc=1 resp=0", rsCyc[1], rsRespAny[1]); end
        compared++;
        if (rsCyc[4] !== 1 || rsRespAny[4] !== 1'b0) begin mismatched++; $display("[TB] FAIL burst_busy2 got cyc=%0d resp=%b want cyc=1 resp=0", rsCyc[4], rsRespAny[4]); end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (rsRdata[6 + k] !== 32'(k + 1)) begin mismatched++; $display("[TB] FAIL burst_read%0d got %h want %h", k, rsRdata[6 + k], 32'(k + 1)); end
        end
    endtask

    task automatic test_back_to_back;
        for (int d = 0; d < 2; d++) begin
            nItems = 0;
            for (int k = 0; k < 48; k++) begin
                int r;
                int sz;
                logic sel;
                logic [1:0] tr;
                r   = int'($urandom_range(0, 9));
                sel = (r != 0);
                tr  = (r == 1) ? 2'd0 : (r == 2) ? 2'd1 : 2'(2 + $urandom_range(0, 1));
                sz  = int'($urandom_range(0, 2));
                addItem(sel, tr, 1'($urandom_range(0, 1)), 16'((int'($urandom_range(0, 127)) >> sz) << sz),
                        3'(sz), $urandom, 3'd1);
            end
            applyStimulus(d);
            for (int k = 0; k < nItems; k++) begin
                logic active;
                int expCyc;
                logic [31:0] m;
                active = sqSel[k] & sqTrans[k][1];
                expCyc = !active ? 1 : (sqWrite[k] ? 1 + wrWait(d) : 1 + rdWait(d));
                compared++;
                if (rsCyc[k] !== expCyc || rsRespAny[k] !== 1'b0) begin
                    mismatched++; $display("[TB] FAIL b2b_phase dut%0d item%0d got cyc=%0d resp=%b want cyc=%0d resp=0", d, k, rsCyc[k], rsRespAny[k], expCyc);
                end
                if (active && !sqWrite[k]) begin
                    m = laneMask(int'(sqAddr[k]), int'(sqSize[k]));
                    compared++;
                    if ((rsRdata[k] & m) !== (mdlWord(d, int'(sqAddr[k])) & m)) begin
                        mismatched++; $display("[TB] FAIL b2b_rdata dut%0d item%0d addr %h got %h want %h", d, k, sqAddr[k], rsRdata[k] & m, mdlWord(d, int'(sqAddr[k])) & m);
                    end
                end
                if (active && sqWrite[k]) mdlWrite(d, int'(sqAddr[k]), int'(sqSize[k]), sqData[k]);
            end
        end
    endtask

    task automatic test_reset_midwait;
        hsel[0] = 1'b1; htrans[0] = 2'd2; hwrite[0] = 1'b1; haddr[0] = 16'h0010; hsize[0] = 3'd2;
        @(negedge clk);
        @(posedge clk); #1;
        busIdle(0);
        hwdata[0] = ~mdlWord(0, 16'h0010);
        @(negedge clk);
        compared++;
        if (hreadyout[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL midwait_stall got %b want 0", hreadyout[0]); end
        rstN = 1'b0;
        #1;
        compared++;
        if (hreadyout[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL midwait_reset_ready got %b want 1", hreadyout[0]); end
        compared++;
        if (hresp[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL midwait_reset_resp got %b want 0", hresp[0]); end
        compared++;
        if (hrdata[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL midwait_reset_rdata got %h want 0", hrdata[0]); end
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b0, 16'h0010, 3'd2, 32'h0, 3'd0);
        applyStimulus(0);
        compared++;
        if (rsRdata[0] !== mdlWord(0, 16'h0010)) begin mismatched++; $display("[TB] FAIL midwait_dropped got %h want %h", rsRdata[0], mdlWord(0, 16'h0010)); end
    endtask

    task automatic test_range;
`ifdef AHB3LITE_SRAM_RANGE_ERR_EN
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b0, 16'h0400, 3'd2, 32'h0, 3'd0);
        addItem(1'b0, 2'd0, 1'b0, 16'h0000, 3'd0, 32'h0, 3'd0);
        addItem(1'b1, 2'd2, 1'b1, 16'h0003, 3'd1, 32'hFFFFFFFF, 3'd0);
        addItem(1'b0, 2'd0, 1'b0, 16'h0000, 3'd0, 32'h0, 3'd0);
        addItem(1'b1, 2'd2, 1'b0, 16'h0000, 3'd2, 32'h0, 3'd0);
        applyStimulus(1);
        for (int k = 0; k <= 2; k += 2) begin
            compared++;
            if (rsCyc[k] !== 2 || rsRespFirst[k] !== 1'b1 || rsRespLast[k] !== 1'b1) begin
                mismatched++; $display("[TB] FAIL err_resp item%0d got cyc=%0d first=%b last=%b want cyc=2 first=1 last=1", k, rsCyc[k], rsRespFirst[k], rsRespLast[k]);
            end
        end
        compared++;
        if (rsRdata[4] !== mdlWord(1, 0)) begin mismatched++; $display("[TB] FAIL err_nowrite got %h want %h", rsRdata[4], mdlWord(1, 0)); end
`else
        nItems = 0;
        addItem(1'b1, 2'd2, 1'b1, 16'h0400, 3'd0, 32'hC3C3C355, 3'd0);
        addItem(1'b1, 2'd2, 1'b0, 16'h0000, 3'd2, 32'h0, 3'd0);
        applyStimulus(1);
        mdlWrite(1, 16'h0400, 0, 32'hC3C3C355);
        compared++;
        if (rsRdata[1][7:0] !== 8'h55) begin mismatched++; $display("[TB] FAIL alias_byte0 got %h want 55", rsRdata[1][7:0]); end
        compared++;
        if (rsRdata[1] !== mdlWord(1, 0)) begin mismatched++; $display("[TB] FAIL alias_word got %h want %h", rsRdata[1], mdlWord(1, 0)); end
        compared++;
        if (rsRespAny[0] !== 1'b0 || rsRespAny[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL alias_resp got %b%b want 00", rsRespAny[0], rsRespAny[1]); end
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        nItems     = 0;
        hprot      = '0;
        for (int d = 0; d < 2; d++) busIdle(d);
        test_reset();
        test_fill();
        test_wait_states();
        test_forwarding();
        test_burst();
        test_back_to_back();
        test_reset_midwait();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
